// File: rtl/pc_redirect_if.sv
// pc_redirect_if: fetch-redirect control bundle between hazard/CP0/D-stage and the PC register
interface pc_redirect_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             Req;
  logic             eret;
  logic [31:0]      EPC;
  logic             br_valid;
  logic [31:0]      br_target;
  logic [31:0]      F_pc4;
  logic [31:0]      npc;
  logic             pc_en;
  logic             flush_D;
  logic             busy_pend;
  logic [CNT_W-1:0] exc_cnt;
  logic [CNT_W-1:0] redir_cnt;
  modport master (
    output stall, Req, eret, EPC, br_valid, br_target, F_pc4,
    input  npc, pc_en, flush_D, busy_pend, exc_cnt, redir_cnt
  );
  modport slave (
    input  stall, Req, eret, EPC, br_valid, br_target, F_pc4,
    output npc, pc_en, flush_D, busy_pend, exc_cnt, redir_cnt
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: next-PC selection, stalled-redirect parking, D-stage flush and redirect counters
module pc_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input logic         clk,
  input logic         reset,
  pc_redirect_if.slave bus
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  logic [1:0]  state;
  logic [31:0] pend_tgt;
  logic        pend_eret;
  logic [3:0]  fcnt;
  logic        go, take_exc, take_eret, take_park, take_br, redirect, to_flush, park_new;
  // decision for this cycle: Req beats eret beats a parked redirect beats a fresh branch
  always_comb begin
    go            = !bus.stall;
    take_exc      = bus.Req;
    take_eret     = !take_exc && state != FLUSH && go && bus.eret;
    take_park     = !take_exc && state == PEND && go && !bus.eret;
    take_br       = !take_exc && state == RUN && go && !bus.eret && bus.br_valid;
    redirect      = take_eret || take_park || take_br;
    to_flush      = take_exc || take_eret || (take_park && pend_eret);
    park_new      = state == RUN && bus.stall && (bus.eret || bus.br_valid);
    bus.npc       = reset     ? bus.F_pc4 :
                    take_exc  ? EXC_VECTOR :
                    take_eret ? bus.EPC :
                    take_park ? pend_tgt :
                    take_br   ? bus.br_target : bus.F_pc4;
    bus.pc_en     = !reset && (take_exc || go);
    bus.flush_D   = !reset && state == FLUSH;
    bus.busy_pend = !reset && state == PEND;
  end
  // state, parked redirect, flush countdown and event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pend_tgt      <= '0;
      pend_eret     <= 1'b0;
      fcnt          <= '0;
      bus.exc_cnt   <= '0;
      bus.redir_cnt <= '0;
    end else begin
      bus.exc_cnt   <= bus.exc_cnt + CNT_W'(take_exc);
      bus.redir_cnt <= bus.redir_cnt + CNT_W'(redirect);
      if (to_flush) begin
        state     <= FLUSH;
        fcnt      <= 4'(FLUSH_CYCLES);
        pend_eret <= 1'b0;
        pend_tgt  <= '0;
      end else if (park_new) begin
        state     <= PEND;
        pend_tgt  <= bus.eret ? bus.EPC : bus.br_target;
        pend_eret <= bus.eret;
      end else if (state == PEND && go) begin
        state     <= RUN;
        pend_eret <= 1'b0;
        pend_tgt  <= '0;
      end else if (state == PEND && bus.eret && !pend_eret) begin
        pend_tgt  <= bus.EPC;
        pend_eret <= 1'b1;
      end else if (state == FLUSH) begin
        state <= fcnt == 4'd1 ? RUN : FLUSH;
        fcnt  <= fcnt - 4'd1;
      end
    end
  end
endmodule
